// File: rtl/octree_feature_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : octree_feature_collector_if
//  Brief    : Handshake bundle between Octree feature output, the collector
//             and its downstream consumer.
//  Revision : 1.0 - initial release
// ============================================================================
interface octree_feature_collector_if #(
    parameter int DATA_BUS_WIDTH = 64,
    parameter int COUNT_WIDTH    = 16
);
    logic [DATA_BUS_WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      search_done;
    logic [DATA_BUS_WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [COUNT_WIDTH-1:0]    rec_count;
    logic                      done;
    logic                      err_partial;

    modport master (
        output in_data, in_valid, search_done, out_ready,
        input  in_ready, out_data, out_valid, out_last, rec_count, done, err_partial
    );

    modport slave (
        input  in_data, in_valid, search_done, out_ready,
        output in_ready, out_data, out_valid, out_last, rec_count, done, err_partial
    );
endinterface
`default_nettype wire

// File: rtl/octree_feature_collector.sv
`default_nettype none
// ============================================================================
//  Module   : octree_feature_collector
//  Brief    : Buffers Octree feature words in a show-ahead FIFO, tags record
//             boundaries and counts complete records per collection.
//  Revision : 1.0 - initial release
// ============================================================================
module octree_feature_collector #(
    parameter int DATA_BUS_WIDTH = 64,
    parameter int FEATURE_LENTH  = 9,
    parameter int FIFO_DEPTH     = 16,
    parameter int COUNT_WIDTH    = 16
) (
    input wire clk,
    input wire rst_n,
    octree_feature_collector_if.slave bus
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_BEAT_W = (FEATURE_LENTH > 1) ? $clog2(FEATURE_LENTH) : 1;

    localparam logic [c_PTR_W:0]       c_FULL      = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]       c_CNT_ONE   = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_BEAT_W-1:0]    c_LAST_BEAT = c_BEAT_W'(FEATURE_LENTH-1);
    localparam logic [c_BEAT_W-1:0]    c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] c_REC_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DATA_BUS_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_PTR_W:0]          r_count;
    logic [c_BEAT_W-1:0]       r_beat;
    logic [COUNT_WIDTH-1:0]    r_rec_count;
    logic                      r_err_partial;
    logic                      r_started;

    logic                      w_accepting;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_out_valid;
    logic                      w_is_last;
    logic                      w_sd_take;
    logic                      w_new_coll;
    logic [c_BEAT_W-1:0]       w_beat_adv;
    logic [COUNT_WIDTH-1:0]    w_rec_base;
    logic [DATA_BUS_WIDTH:0]   w_head;

    // r_started keeps in_ready low until the first edge after reset release
    assign w_accepting = (r_state == IDLE) || (r_state == COLLECT);
    assign bus.in_ready = r_started && w_accepting && (r_count < c_FULL);

    assign w_push      = bus.in_valid && bus.in_ready;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_is_last   = (r_beat == c_LAST_BEAT);
    assign w_sd_take   = bus.search_done && w_accepting;
    assign w_new_coll  = w_push && (r_state == IDLE);
    assign w_beat_adv  = w_push ? (w_is_last ? '0 : r_beat + c_BEAT_ONE) : r_beat;
    assign w_rec_base  = w_new_coll ? '0 : r_rec_count;

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_out_valid ? w_head[DATA_BUS_WIDTH-1:0] : '0;
    assign bus.out_last    = w_out_valid && w_head[DATA_BUS_WIDTH];
    assign bus.rec_count   = r_rec_count;
    assign bus.err_partial = r_err_partial;
    assign bus.done        = (r_state == DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_sd_take) begin
                    w_state_nxt = DRAIN;
                end else if (w_push) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_sd_take) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // No pushes happen here, so a pop of the only entry empties the FIFO
                if ((r_count == '0) || ((r_count == c_CNT_ONE) && w_pop)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_is_last, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_beat        <= '0;
            r_rec_count   <= '0;
            r_err_partial <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_beat <= w_sd_take ? '0 : w_beat_adv;

            if (w_push && w_is_last && (w_rec_base != '1)) begin
                r_rec_count <= w_rec_base + c_REC_ONE;
            end else begin
                r_rec_count <= w_rec_base;
            end

            // A truncated record at search end wins over the new-collection clear
            if (w_sd_take && (w_beat_adv != '0)) begin
                r_err_partial <= 1'b1;
            end else if (w_new_coll) begin
                r_err_partial <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_octree_feature_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_octree_feature_collector
//  Brief    : Directed bench for octree_feature_collector with a queue-based
//             reference model compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_octree_feature_collector;

    localparam int DW    = 64;
    localparam int L     = 9;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    octree_feature_collector_if #(.DATA_BUS_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    octree_feature_collector #(
        .DATA_BUS_WIDTH(DW),
        .FEATURE_LENTH (L),
        .FIFO_DEPTH    (DEPTH),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks      = 0;
    int failures    = 0;
    int done_pulses = 0;
    bit rand_bp     = 1'b0;

    logic [DW-1:0] rx_data[$];
    logic          rx_last[$];

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done
    logic [DW:0] m_q[$];
    int          m_phase   = 0;
    int          m_beat    = 0;
    int          m_recs    = 0;
    bit          m_err     = 1'b0;
    bit          m_started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return m_started && (m_phase <= 1) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_step();
        bit push;
        bit pop;
        bit lst;
        int ph0;
        ph0  = m_phase;
        push = bus.in_valid && exp_ready();
        pop  = (m_q.size() > 0) && bus.out_ready;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            lst = (m_beat == L - 1);
            m_q.push_back({lst, bus.in_data});
            if (ph0 == 0) begin
                m_recs = 0;
                m_err  = 1'b0;
            end
            m_beat = lst ? 0 : m_beat + 1;
            if (lst && (m_recs < (1 << CW) - 1)) m_recs++;
        end
        case (ph0)
            0, 1: begin
                if (bus.search_done) begin
                    if (m_beat != 0) m_err = 1'b1;
                    m_beat  = 0;
                    m_phase = 2;
                end else if (push) begin
                    m_phase = 1;
                end
            end
            2: if (m_q.size() == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_started = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_phase   = 0;
                m_beat    = 0;
                m_recs    = 0;
                m_err     = 1'b0;
                m_started = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        logic [DW:0] h;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", bus.in_ready, exp_ready());
                check("out_valid", bus.out_valid, m_q.size() > 0);
                if (m_q.size() > 0) begin
                    h = m_q[0];
                    check("out_data", bus.out_data, h[DW-1:0]);
                    check("out_last", bus.out_last, h[DW]);
                end
                check("done", bus.done, m_phase == 3);
                check("rec_count", bus.rec_count, m_recs);
                check("err_partial", bus.err_partial, m_err);
                if (bus.done) done_pulses++;
                if (bus.out_valid && bus.out_ready) begin
                    rx_data.push_back(bus.out_data);
                    rx_last.push_back(bus.out_last);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // All driver tasks start and end at 1 time unit after a rising edge
    task automatic send_word(input logic [DW-1:0] d, input bit sd);
        int t = 0;
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            bus.search_done = sd && bus.in_ready;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            bus.search_done = 1'b0;
            t++;
        end while (!acc && t < 300);
        bus.in_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic pulse_sd();
        bus.search_done = 1'b1;
        @(posedge clk);
        #1;
        bus.search_done = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int t = 0;
        bit seen = 1'b0;
        while (!seen && t < max) begin
            @(negedge clk);
            seen = bus.done;
            t++;
        end
        @(posedge clk);
        #1;
        check("done_seen", seen, 1'b1);
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        done_pulses = 0;
    endtask

    task automatic check_seq(input string name, input int n, input int off, input int mul);
        check({name, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_data.size()) begin
                check({name, "_data"}, rx_data[i], 64'(off + i * mul));
                check({name, "_last"}, rx_last[i], (i % L) == L - 1);
            end
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.search_done = 1'b0;
        bus.out_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err_partial, 1'b0);
        check("rst_rec", bus.rec_count, 16'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after_edge", bus.in_ready, 1'b1);

        // One complete record with free-flowing output
        bus.out_ready = 1'b1;
        clear_rx();
        for (int i = 0; i < 9; i++) send_word(64'(i), 1'b0);
        pulse_sd();
        wait_done(50);
        repeat (3) @(posedge clk);
        #1;
        check_seq("s1", 9, 0, 1);
        check("s1_rec", bus.rec_count, 16'd1);
        check("s1_err", bus.err_partial, 1'b0);
        check("s1_done_pulses", done_pulses, 1);

        // Fill to capacity under backpressure, then release
        bus.out_ready = 1'b0;
        clear_rx();
        for (int i = 0; i < 16; i++) send_word(64'(100 + i), 1'b0);
        check("s2_full_ready", bus.in_ready, 1'b0);
        check("s2_head", bus.out_data, 64'd100);
        repeat (2) @(posedge clk);
        #1;
        check("s2_head_hold", bus.out_data, 64'd100);
        check("s2_full_hold", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        send_word(64'd116, 1'b0);
        send_word(64'd117, 1'b0);
        pulse_sd();
        wait_done(100);
        check_seq("s2", 18, 100, 1);
        check("s2_rec", bus.rec_count, 16'd2);

        // Truncated record flags err_partial until next collection starts
        clear_rx();
        for (int i = 0; i < 5; i++) send_word(64'(200 + i), 1'b0);
        pulse_sd();
        wait_done(50);
        check_seq("s3", 5, 200, 1);
        check("s3_err", bus.err_partial, 1'b1);
        check("s3_rec", bus.rec_count, 16'd0);
        check("s3_done_pulses", done_pulses, 1);
        send_word(64'd300, 1'b0);
        check("s3_err_cleared", bus.err_partial, 1'b0);
        for (int i = 1; i < 9; i++) send_word(64'(300 + i), 1'b0);
        pulse_sd();
        wait_done(50);
        check("s3b_rec", bus.rec_count, 16'd1);

        // search_done coincides with the final word's acceptance
        clear_rx();
        for (int i = 0; i < 9; i++) send_word(64'(400 + i), i == 8);
        wait_done(50);
        check_seq("s4", 9, 400, 1);
        check("s4_rec", bus.rec_count, 16'd1);
        check("s4_err", bus.err_partial, 1'b0);

        // Reset with words buffered discards them silently
        bus.out_ready = 1'b0;
        clear_rx();
        for (int i = 0; i < 7; i++) send_word(64'(500 + i), 1'b0);
        check("s5_buffered", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_valid", bus.out_valid, 1'b0);
        check("s5_rst_data", bus.out_data, 64'd0);
        check("s5_rst_rec", bus.rec_count, 16'd0);
        check("s5_rst_ready", bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("s5_no_rx", rx_data.size(), 0);
        check("s5_no_done", done_pulses, 0);
        for (int i = 0; i < 9; i++) send_word(64'(600 + i), 1'b0);
        pulse_sd();
        wait_done(50);
        check_seq("s5", 9, 600, 1);
        check("s5_rec", bus.rec_count, 16'd1);

        // Random output backpressure across ten records
        clear_rx();
        rand_bp = 1'b1;
        for (int i = 0; i < 90; i++) send_word(64'(1000 + 3 * i), 1'b0);
        pulse_sd();
        wait_done(400);
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        check_seq("s6", 90, 1000, 3);
        check("s6_rec", bus.rec_count, 16'd10);
        check("s6_err", bus.err_partial, 1'b0);
        check("s6_done_pulses", done_pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/octree_feature_collector.md
OCTREE_FEATURE_COLLECTOR -- requirements
Module: octree_feature_collector

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 64, width of each feature word.
REQ-002 Parameter FEATURE_LENTH, default 9, words per feature record.
REQ-003 Parameter FIFO_DEPTH, default 16, word-FIFO entries, a power of two and at least FEATURE_LENTH.
REQ-004 Parameter COUNT_WIDTH, default 16, width of the record counter.
REQ-005 clk  input  1  single clock; all flops on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_data  input  DATA_BUS_WIDTH  feature word from the Octree feature_out.
REQ-008 in_valid  input  1  upstream word valid.
REQ-009 in_ready  output  1  collector can accept a word this cycle.
REQ-010 search_done  input  1  one-cycle pulse from Octree meaning the search has finished.
REQ-011 out_data  output  DATA_BUS_WIDTH  buffered feature word at the FIFO head.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_last  output  1  out_data is the final word of its record.
REQ-015 rec_count  output  COUNT_WIDTH  number of complete records accepted in the current collection.
REQ-016 done  output  1  one-cycle pulse when the collection is fully drained.
REQ-017 err_partial  output  1  sticky flag: search_done arrived with an incomplete record.

Function
REQ-018 The FSM SHALL have four states: IDLE, COLLECT, DRAIN and DONE.
REQ-019 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL be 1 only in IDLE or COLLECT, and only while FIFO occupancy is below FIFO_DEPTH; there SHALL be no pass-through when full, even if a pop occurs in the same cycle.
REQ-021 A transfer accepted in IDLE SHALL clear rec_count and err_partial, and the FSM SHALL go to COLLECT.
REQ-022 The beat counter SHALL count 0 to FEATURE_LENTH-1; each input transfer advances it; it wraps to 0 after FEATURE_LENTH-1.
REQ-023 The last flag SHALL be stored with each word: it is 1 exactly when the beat counter equals FEATURE_LENTH-1 at acceptance.
REQ-024 rec_count SHALL increment on acceptance of a last word, and SHALL saturate at its all-ones value.
REQ-025 The FIFO SHALL be show-ahead: a word accepted in cycle N SHALL be visible on out_data/out_valid/out_last in cycle N+1 when the FIFO was empty.
REQ-026 out_data SHALL hold stable while out_valid is 1 and out_ready is 0.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged, and the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 search_done in IDLE or COLLECT SHALL move the FSM to DRAIN; search_done in DRAIN or DONE SHALL be ignored.
REQ-029 If search_done coincides with an input transfer, that word SHALL be accepted first; the partial check then uses the post-advance beat counter.
REQ-030 On entering DRAIN with a beat counter other than 0, err_partial SHALL be set and the beat counter SHALL be cleared to 0.
REQ-031 In DRAIN, when the FIFO is empty (including the same cycle the last pop completes), the FSM SHALL go to DONE.
REQ-032 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-033 rec_count and err_partial SHALL hold their values in IDLE until the next collection starts.
REQ-034 search_done in IDLE with no words accepted SHALL go DRAIN, then DONE, then IDLE, with rec_count=0.

Reset
REQ-035 While rst_n is 0, the following SHALL be forced asynchronously: FSM=IDLE; FIFO pointers, occupancy, beat counter and rec_count=0; in_ready=0, out_valid=0, out_last=0, done=0, err_partial=0, out_data=0.
REQ-036 in_ready SHALL rise no earlier than the first clk edge after rst_n deasserts.
REQ-037 Reset mid-collection SHALL discard all buffered words without emitting done.

Verification
REQ-038 Scenario: 9 words 0..8 with out_ready=1, then search_done -> outputs 0..8 each one cycle after acceptance; out_last only on word 8; rec_count=1; done pulses once; err_partial=0.
REQ-039 Scenario: 18 words with out_ready=0 -> in_ready falls after 16 accepts; raising out_ready resumes flow; all 18 words arrive in order; rec_count=2.
REQ-040 Scenario: 5 words then search_done -> err_partial=1; 5 words drained with no out_last; done pulses; the next collection's first accept clears err_partial.
REQ-041 Scenario: search_done in the same cycle as the 9th word's acceptance -> rec_count=1, err_partial=0, word 8 drained with out_last=1.
REQ-042 Scenario: rst_n pulsed low with 7 words buffered -> out_valid=0 immediately; rec_count=0; no done pulse; a normal 9-word collection afterwards passes.
REQ-043 Scenario: random out_ready backpressure over 90 words -> 90 words in order with no loss or duplication; rec_count=10.
